// File: rtl/sipo_deframer.sv
// rtl/sipo_deframer.sv - framed serial-to-parallel receiver with one-word holding register and sticky errors
module sipo_deframer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic             frame_err,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] shifted_word;
    logic             word_done;
    logic             frame_evt;
    logic             drain;
    logic             load;

    // First bit enters at the end that will eventually become b0's home.
    always_comb begin
        if (MSB_FIRST) begin
            first_word   = {{(WIDTH-1){1'b0}}, sin};
            shifted_word = {shreg[WIDTH-2:0], sin};
        end else begin
            first_word   = {sin, {(WIDTH-1){1'b0}}};
            shifted_word = {sin, shreg[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        word_done = 1'b0;
        frame_evt = 1'b0;
        if (sin_valid) begin
            case (state)
                IDLE: begin
                    if (sin_start) begin
                        shreg_nxt = first_word;
                        cnt_nxt   = CW'(1);
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sin_start) begin
                        frame_evt = 1'b1;
                        shreg_nxt = first_word;
                        cnt_nxt   = CW'(1);
                    end else begin
                        shreg_nxt = shifted_word;
                        if (cnt == CW'(WIDTH - 1)) begin
                            word_done = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign drain = out_valid & out_ready;
    assign load  = word_done & (~out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            if (load) begin
                out_data  <= shreg_nxt;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            // A new event on the clearing edge wins over the clear.
            frame_err <= (frame_err & ~err_clr) | frame_evt;
            overflow  <= (overflow & ~err_clr) | (word_done & ~load);
        end
    end

endmodule

// File: tb/tb_sipo_deframer.sv
// tb/tb_sipo_deframer.sv - directed scoreboard bench for sipo_deframer (WIDTH=4, MSB first)
module tb_sipo_deframer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sin, sin_valid, sin_start;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err_clr;
    logic       frame_err, overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [3:0] sb_q[$];

    sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_start (sin_start),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every transfer edge must match the next expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", {28'h0, out_data}, 32'hdead);
            end else begin
                chk("sb_word", {28'h0, out_data}, {28'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        sin       = b;
        sin_start = st;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        sin_start = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send_bit(w[i], i == 3);
    endtask

    int s;
    logic [3:0] w5;

    initial begin
        rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick();

        // Basic word, latency one cycle after last bit
        sb_q.push_back(4'b1011);
        s = cyc;
        send_bit(1, 1); send_bit(0, 0); send_bit(1, 0);
        chk("t1_not_yet", out_valid, 0);
        send_bit(1, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 4'b1011);
        chk("t1_lat", cyc - s, 4);
        tick();
        chk("t1_fall", out_valid, 0);
        chk("t1_noerr", {frame_err, overflow}, 0);

        // Same stream with a 3-cycle stall between bits 2 and 3
        sb_q.push_back(4'b1011);
        s = cyc;
        send_bit(1, 1); send_bit(0, 0);
        tick(); tick(); tick();
        send_bit(1, 0);
        chk("t2_not_yet", out_valid, 0);
        send_bit(1, 0);
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 4'b1011);
        chk("t2_lat", cyc - s, 7);
        tick();

        // Overflow: second word dropped while first is held
        out_ready = 1'b0;
        send_word(4'hA);
        chk("t3_holdA", out_data, 4'hA);
        chk("t3_validA", out_valid, 1);
        send_word(4'h5);
        chk("t3_ovf", overflow, 1);
        chk("t3_stillA", out_data, 4'hA);
        chk("t3_still_valid", out_valid, 1);
        sb_q.push_back(4'hA);
        out_ready = 1'b1;
        tick();
        chk("t3_drained", out_valid, 0);
        chk("t3_sb_empty", sb_q.size(), 0);
        tick();
        chk("t3_no5", out_valid, 0);

        // Framing error and recovery on the restarted word
        send_bit(1, 1); send_bit(1, 0);
        chk("t4_ferr_pre", frame_err, 0);
        sb_q.push_back(4'b0110);
        send_bit(0, 1);
        chk("t4_ferr", frame_err, 1);
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        chk("t4_data", out_data, 4'b0110);
        chk("t4_valid", out_valid, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_ferr_clr", frame_err, 0);
        chk("t4_ovf_clr", overflow, 0);

        // Back-to-back words: one valid cycle every four
        sb_q.push_back(4'h3); sb_q.push_back(4'hC); sb_q.push_back(4'h9);
        for (int k = 0; k < 12; k++) begin
            case (k / 4)
                0: w5 = 4'h3;
                1: w5 = 4'hC;
                default: w5 = 4'h9;
            endcase
            send_bit(w5[3 - (k % 4)], (k % 4) == 0);
            chk($sformatf("t5_valid_%0d", k), out_valid, (k % 4) == 3);
        end
        tick();
        chk("t5_sb_empty", sb_q.size(), 0);
        chk("t5_no_ovf", overflow, 0);
        chk("t5_no_ferr", frame_err, 0);

        // Reset mid-word with a held word, then recover
        out_ready = 1'b0;
        send_word(4'h7);
        chk("t6_held", out_valid, 1);
        send_bit(1, 1); send_bit(0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        out_ready = 1'b1;
        sb_q.push_back(4'hF);
        send_word(4'hF);
        chk("t6_valid", out_valid, 1);
        chk("t6_data", out_data, 4'hF);
        tick();
        chk("t6_sb_empty", sb_q.size(), 0);
        chk("t6_errs", {frame_err, overflow}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
